// File: rtl/duck_pkg.sv
// Shared definitions for the duck-hunt round tracker: parameter defaults,
// score ceiling and the tracker state encoding.
package duck_pkg;

    localparam int unsigned SHOTS_DEFAULT          = 3;
    localparam int unsigned FLIGHT_TICKS_DEFAULT   = 300;
    localparam int unsigned FLEE_TICKS_DEFAULT     = 60;
    localparam int unsigned BIRDS_PER_GAME_DEFAULT = 10;
    localparam int unsigned POINTS_DEFAULT         = 500;
    localparam int unsigned SCORE_MAX              = 999_999;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLYING   = 2'd1,
        RESOLVED = 2'd2
    } tracker_state_e;

endpackage

// File: rtl/flight_timer.sv
// Frame-tick flight counter: counts ticks while enabled, can be raised to a
// floor value, and flags the tick on which the count reaches LIMIT.
module flight_timer #(
    parameter int unsigned LIMIT = 300,
    parameter int unsigned W     = $clog2(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    input  logic         tick,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    localparam logic [W-1:0] LIMIT_W = W'(LIMIT);
    localparam logic [W-1:0] LAST_W  = W'(LIMIT - 1);

    logic [W-1:0] count_q, count_d, count_inc;

    always_comb begin
        count_inc = count_q;
        if (en && tick && count_q != LIMIT_W) begin
            count_inc = count_q + W'(1);
        end
        count_d = count_inc;
        // load only ever raises the count, so a later floor never rewinds time
        if (load && en && count_inc < load_val) begin
            count_d = load_val;
        end
        if (clear) begin
            count_d = '0;
        end
        expire = en && tick && !clear && (count_q == LAST_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/round_tracker.sv
// Per-round duck tracker: shells, flight time, hit/escape resolution and
// game-wide bird, hit and score counters.
module round_tracker
    import duck_pkg::*;
#(
    parameter int unsigned SHOTS          = SHOTS_DEFAULT,
    parameter int unsigned FLIGHT_TICKS   = FLIGHT_TICKS_DEFAULT,
    parameter int unsigned FLEE_TICKS     = FLEE_TICKS_DEFAULT,
    parameter int unsigned BIRDS_PER_GAME = BIRDS_PER_GAME_DEFAULT,
    parameter int unsigned POINTS         = POINTS_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        new_round,
    input  logic        reset_shots,
    input  logic        reset_score,
    input  logic        reset_birds,
    input  logic        tick,
    input  logic        trigger,
    input  logic        hit,
    output logic        no_shots_left,
    output logic        bird_shot,
    output logic        flew_away,
    output logic        game_over,
    output logic [1:0]  shots_left,
    output logic [3:0]  birds_done,
    output logic [3:0]  hits,
    output logic [19:0] score
);

    localparam int unsigned    TW          = $clog2(FLIGHT_TICKS + 1);
    localparam logic [TW-1:0]  FLEE_START  = TW'(FLIGHT_TICKS - FLEE_TICKS);
    localparam logic [1:0]     SHOTS_L     = 2'(SHOTS);
    localparam logic [3:0]     BIRDS_L     = 4'(BIRDS_PER_GAME);
    localparam logic [20:0]    POINTS_L    = 21'(POINTS);
    localparam logic [20:0]    SCORE_MAX_L = 21'(SCORE_MAX);

    tracker_state_e state_q, state_d;
    logic [1:0]  shots_left_q, shots_left_d;
    logic [3:0]  birds_done_q, birds_done_d;
    logic [3:0]  hits_q, hits_d;
    logic [19:0] score_q, score_d;
    logic        bird_shot_q, bird_shot_d;
    logic        flew_away_q, flew_away_d;
    logic        trig_prev_q, trig_prev_d;

    logic        flying, shot_ok, shot_hit, last_miss, expire, flee, resolve;
    logic [20:0] score_sum;

    assign flying = (state_q == FLYING);

    flight_timer #(
        .LIMIT (FLIGHT_TICKS),
        .W     (TW)
    ) u_flight_timer (
        .clk      (Clk),
        .rst      (Reset),
        .clear    (new_round),
        .en       (flying),
        .tick     (tick),
        .load     (last_miss),
        .load_val (FLEE_START),
        .expire   (expire)
    );

    always_comb begin
        shot_ok   = flying && trigger && !trig_prev_q && (shots_left_q != 2'd0) && !new_round;
        shot_hit  = shot_ok && hit;
        last_miss = shot_ok && !hit && (shots_left_q == 2'd1) && !reset_shots;
        flee      = expire && !shot_hit && !new_round;
        resolve   = shot_hit || flee;
        score_sum = {1'b0, score_q} + POINTS_L;

        state_d      = state_q;
        shots_left_d = shots_left_q;
        birds_done_d = birds_done_q;
        hits_d       = hits_q;
        score_d      = score_q;
        bird_shot_d  = bird_shot_q;
        flew_away_d  = flew_away_q;
        trig_prev_d  = trigger;

        if (new_round) begin
            state_d     = FLYING;
            bird_shot_d = 1'b0;
            flew_away_d = 1'b0;
        end else if (resolve) begin
            state_d     = RESOLVED;
            bird_shot_d = shot_hit;
            flew_away_d = flee;
        end

        if (reset_shots) begin
            shots_left_d = SHOTS_L;
        end else if (shot_ok) begin
            shots_left_d = shots_left_q - 2'd1;
        end

        if (reset_birds) begin
            birds_done_d = '0;
            hits_d       = '0;
        end else begin
            if (resolve && birds_done_q < BIRDS_L) birds_done_d = birds_done_q + 4'd1;
            if (shot_hit && hits_q < BIRDS_L)      hits_d       = hits_q + 4'd1;
        end

        if (reset_score) begin
            score_d = '0;
        end else if (shot_hit) begin
            score_d = (score_sum > SCORE_MAX_L) ? SCORE_MAX_L[19:0] : score_sum[19:0];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            shots_left_q <= SHOTS_L;
            birds_done_q <= '0;
            hits_q       <= '0;
            score_q      <= '0;
            bird_shot_q  <= 1'b0;
            flew_away_q  <= 1'b0;
            trig_prev_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            shots_left_q <= shots_left_d;
            birds_done_q <= birds_done_d;
            hits_q       <= hits_d;
            score_q      <= score_d;
            bird_shot_q  <= bird_shot_d;
            flew_away_q  <= flew_away_d;
            trig_prev_q  <= trig_prev_d;
        end
    end

    assign no_shots_left = (shots_left_q == 2'd0);
    assign game_over     = (birds_done_q == BIRDS_L);
    assign shots_left    = shots_left_q;
    assign birds_done    = birds_done_q;
    assign hits          = hits_q;
    assign score         = score_q;
    assign bird_shot     = bird_shot_q;
    assign flew_away     = flew_away_q;

endmodule

// File: tb/tb_round_tracker.sv
// Directed-vector bench for round_tracker with default parameters.
module tb_round_tracker;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        new_round = 1'b0, reset_shots = 1'b0, reset_score = 1'b0, reset_birds = 1'b0;
    logic        tick = 1'b0, trigger = 1'b0, hit = 1'b0;
    logic        no_shots_left, bird_shot, flew_away, game_over;
    logic [1:0]  shots_left;
    logic [3:0]  birds_done, hits;
    logic [19:0] score;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    round_tracker dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .new_round     (new_round),
        .reset_shots   (reset_shots),
        .reset_score   (reset_score),
        .reset_birds   (reset_birds),
        .tick          (tick),
        .trigger       (trigger),
        .hit           (hit),
        .no_shots_left (no_shots_left),
        .bird_shot     (bird_shot),
        .flew_away     (flew_away),
        .game_over     (game_over),
        .shots_left    (shots_left),
        .birds_done    (birds_done),
        .hits          (hits),
        .score         (score)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    task automatic start_round(input logic reload);
        new_round   = 1'b1;
        reset_shots = reload;
        step();
        new_round   = 1'b0;
        reset_shots = 1'b0;
    endtask

    task automatic fire(input logic h);
        trigger = 1'b1;
        hit     = h;
        step();
        trigger = 1'b0;
        hit     = 1'b0;
        step();
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
        end
        tick = 1'b0;
    endtask

    initial begin
        // reset state
        step();
        do_reset();
        check_eq("rst_shots", shots_left, 3);
        check_eq("rst_score", score, 0);
        check_eq("rst_birds", birds_done, 0);
        check_eq("rst_hits", hits, 0);
        check_eq("rst_shot", bird_shot, 0);
        check_eq("rst_flew", flew_away, 0);
        check_eq("rst_gover", game_over, 0);
        check_eq("rst_noshot", no_shots_left, 0);

        // single hit
        reset_shots = 1'b1; step(); reset_shots = 1'b0;
        start_round(1'b0);
        trigger = 1'b1; hit = 1'b1; step();
        check_eq("hit_shot", bird_shot, 1);
        check_eq("hit_shots", shots_left, 2);
        check_eq("hit_score", score, 500);
        check_eq("hit_hits", hits, 1);
        check_eq("hit_birds", birds_done, 1);
        trigger = 1'b0; hit = 1'b0; step();
        fire(1'b0);
        check_eq("resolved_ign", shots_left, 2);

        // duck escapes on tick 300
        start_round(1'b1);
        ticks(299);
        check_eq("esc_299", flew_away, 0);
        ticks(1);
        check_eq("esc_flew", flew_away, 1);
        check_eq("esc_shot", bird_shot, 0);
        check_eq("esc_birds", birds_done, 2);
        check_eq("esc_shots", shots_left, 3);
        ticks(5);
        check_eq("esc_once", birds_done, 2);

        // three misses shorten the flight
        do_reset();
        start_round(1'b0);
        ticks(10);
        fire(1'b0); fire(1'b0); fire(1'b0);
        check_eq("miss_noshot", no_shots_left, 1);
        check_eq("miss_shots", shots_left, 0);
        fire(1'b0);
        check_eq("miss_4th", shots_left, 0);
        ticks(59);
        check_eq("flee_59", flew_away, 0);
        ticks(1);
        check_eq("flee_60", flew_away, 1);
        check_eq("flee_birds", birds_done, 1);

        // hit on the expiry tick
        do_reset();
        start_round(1'b0);
        ticks(299);
        tick = 1'b1; trigger = 1'b1; hit = 1'b1; step();
        tick = 1'b0; trigger = 1'b0; hit = 1'b0;
        check_eq("tie_shot", bird_shot, 1);
        check_eq("tie_flew", flew_away, 0);
        check_eq("tie_birds", birds_done, 1);
        ticks(3);
        check_eq("tie_once", birds_done, 1);

        // full game and saturation
        do_reset();
        for (int unsigned r = 0; r < 9; r++) begin
            start_round(1'b1);
            fire(1'b1);
        end
        check_eq("game9_over", game_over, 0);
        check_eq("game9_birds", birds_done, 9);
        start_round(1'b1);
        fire(1'b1);
        check_eq("game10_over", game_over, 1);
        check_eq("game10_hits", hits, 10);
        check_eq("game10_score", score, 5000);
        start_round(1'b1);
        fire(1'b1);
        check_eq("sat_birds", birds_done, 10);
        check_eq("sat_hits", hits, 10);
        check_eq("game11_score", score, 5500);
        reset_birds = 1'b1; reset_score = 1'b1; step();
        reset_birds = 1'b0; reset_score = 1'b0;
        check_eq("clr_over", game_over, 0);
        check_eq("clr_score", score, 0);
        check_eq("clr_birds", birds_done, 0);
        check_eq("clr_hits", hits, 0);

        // score ceiling: 1999 hits = 999500, the 2000th clamps
        for (int unsigned r = 0; r < 1999; r++) begin
            start_round(1'b1);
            fire(1'b1);
        end
        check_eq("score_1999", score, 999_500);
        start_round(1'b1);
        fire(1'b1);
        check_eq("score_sat", score, 999_999);

        // held trigger through reset does not fire
        trigger = 1'b1;
        do_reset();
        start_round(1'b0);
        step(); step();
        check_eq("held_noshot", shots_left, 3);
        trigger = 1'b0; step();
        trigger = 1'b1; step();
        check_eq("repress_shot", shots_left, 2);
        trigger = 1'b0; step();

        // overrides
        reset_shots = 1'b1; trigger = 1'b1; step();
        reset_shots = 1'b0; trigger = 1'b0;
        check_eq("rs_over_shot", shots_left, 3);
        step();
        new_round = 1'b1; trigger = 1'b1; hit = 1'b1; step();
        new_round = 1'b0; trigger = 1'b0; hit = 1'b0;
        check_eq("nr_over_shot", bird_shot, 0);
        check_eq("nr_over_shots", shots_left, 3);
        check_eq("nr_over_hits", hits, 0);
        step();
        reset_score = 1'b1; trigger = 1'b1; hit = 1'b1; step();
        reset_score = 1'b0; trigger = 1'b0; hit = 1'b0;
        check_eq("rsc_score", score, 0);
        check_eq("rsc_hits", hits, 1);
        check_eq("rsc_shot", bird_shot, 1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/round_tracker.md
ROUND_TRACKER -- requirements
Module: round_tracker

Interface
REQ-001 Parameter SHOTS, default 3, shells loaded per round.
REQ-002 Parameter FLIGHT_TICKS, default 300, frame ticks a duck stays airborne (5 s at 60 Hz).
REQ-003 Parameter FLEE_TICKS, default 60, remaining-time cap once shells run out.
REQ-004 Parameter BIRDS_PER_GAME, default 10, rounds per game.
REQ-005 Parameter POINTS, default 500, score per hit.
REQ-006 Ports, one per line:
  Clk  in  1  system clock; one clock; all logic on posedge
  Reset  in  1  synchronous, active-high reset
  new_round  in  1  one-cycle pulse from game control: arm a new round
  reset_shots  in  1  level: reload shells
  reset_score  in  1  level: clear score
  reset_birds  in  1  level: clear bird and hit counts
  tick  in  1  one-cycle frame strobe
  trigger  in  1  raw fire-button level
  hit  in  1  crosshair over live duck, sampled with trigger edge
  no_shots_left  out  1  shots_left == 0
  bird_shot  out  1  sticky: duck hit this round
  flew_away  out  1  sticky: duck escaped this round
  game_over  out  1  birds_done == BIRDS_PER_GAME
  shots_left  out  2  shells remaining
  birds_done  out  4  rounds resolved this game
  hits  out  4  ducks hit this game
  score  out  20  binary score, saturating at 999_999

Function
REQ-007 States: IDLE, FLYING, RESOLVED; a new_round pulse in any state enters FLYING, clears timer, bird_shot, flew_away.
REQ-008 Shot = rising edge of trigger (registered previous level); accepted only in FLYING with shots_left > 0.
REQ-009 Accepted shot decrements shots_left the following cycle; shots_left never wraps below 0.
REQ-010 Accepted shot with hit=1: bird_shot=1, hits+1, score+POINTS (saturate 999_999), state -> RESOLVED, birds_done+1, all on the next clock edge.
REQ-011 In FLYING, each tick increments timer; timer reaching FLIGHT_TICKS sets flew_away=1, state -> RESOLVED, birds_done+1.
REQ-012 When shots_left becomes 0 without a hit, timer is raised to FLIGHT_TICKS-FLEE_TICKS if currently lower.
REQ-013 Hit and timer expiry in the same cycle: hit wins; flew_away stays 0.
REQ-014 birds_done increments exactly once per round; it and hits saturate at BIRDS_PER_GAME.
REQ-015 In RESOLVED and IDLE, triggers are ignored (no decrement) and timer holds.
REQ-016 reset_shots loads shots_left=SHOTS and overrides a same-cycle shot.
REQ-017 new_round overrides a same-cycle trigger edge or tick.
REQ-018 reset_score clears score; reset_birds clears birds_done and hits; each overrides same-cycle increments.
REQ-019 no_shots_left and game_over are combinational from registered counts; all other outputs are registered.

Reset
REQ-020 Reset: state IDLE, shots_left=SHOTS, timer=0, score=0, birds_done=0, hits=0, bird_shot=0, flew_away=0, trigger history=1 (a held button does not fire).
REQ-021 Reset mid-round discards the round with no counter update; Reset has priority over every input.

Structure
REQ-022 Shared package duck_pkg holds the parameter defaults, SCORE_MAX=999_999, and the tracker state enum.
REQ-023 Flight countdown is one sub-module, flight_timer (load, clear, tick, expire).

Verification
REQ-024 Reset, reset_shots, new_round, trigger edge with hit=1 -> next cycle bird_shot=1, shots_left=2, score=500, hits=1, birds_done=1.
REQ-025 new_round, 300 ticks, no trigger -> flew_away=1 on tick 300, bird_shot=0, birds_done=1, shots_left=3.
REQ-026 Three misses at tick 10 -> no_shots_left=1, timer=240, flew_away after 60 more ticks; fourth trigger leaves shots_left=0.
REQ-027 Hit and 300th tick same cycle -> bird_shot=1, flew_away=0, birds_done+1 once.
REQ-028 Ten rounds each resolved -> game_over=1 at birds_done=10; reset_birds and reset_score -> game_over=0, score=0.
REQ-029 Trigger held high through Reset then new_round -> no shot until release and re-press.
